// File: rtl/servo_pkg.sv
// Shared types for the multi-channel servo PWM block: channel state, angle type
// and the angle clamp used by command decode.
package servo_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        FAULT = 2'd2
    } ch_state_t;

    localparam int ANGLE_MAX = 180;

    typedef logic [7:0] angle_t;

    function automatic angle_t clamp_angle(input angle_t a);
        return (a > angle_t'(ANGLE_MAX)) ? angle_t'(ANGLE_MAX) : a;
    endfunction

endpackage

// File: rtl/servo_pwm_multi_if.sv
// Command channel of servo_pwm_multi: one angle command per transfer.
interface servo_pwm_multi_if import servo_pkg::*; #(
    parameter int N_CH = 4
);
    localparam int CH_W = (N_CH > 1) ? $clog2(N_CH) : 1;

    // A command transfers on a rising clk edge where cmd_valid && cmd_ready;
    // the master holds cmd_ch/cmd_angle stable while cmd_valid is high and not yet accepted.
    logic            cmd_valid;
    logic            cmd_ready;
    logic [CH_W-1:0] cmd_ch;
    angle_t          cmd_angle;

    modport master (output cmd_valid, cmd_ch, cmd_angle, input cmd_ready);
    modport slave  (input cmd_valid, cmd_ch, cmd_angle, output cmd_ready);

endinterface

// File: rtl/servo_ch.sv
// One servo channel: IDLE/RUN/FAULT state, slew-limited angle, overcurrent
// counting and the registered PWM output. All state moves only on update.
module servo_ch import servo_pkg::*; #(
    parameter int CNT_W         = 21,
    parameter int PULSE_MIN_CYC = 100000,
    parameter int CYC_PER_DEG   = 555,
    parameter int SLEW_DEG      = 5,
    parameter int CUR_W         = 12,
    parameter int OC_LIMIT      = 3000,
    parameter int OC_FRAMES     = 3,
    parameter int RESET_ANGLE   = 90
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [CNT_W-1:0] cnt,
    input  logic             update,
    input  logic             en,
    input  logic             fault_clr,
    input  logic [CUR_W-1:0] current,
    input  logic             wr,
    input  angle_t           wr_angle,
    output logic             pwm,
    output logic             busy,
    output ch_state_t        state
);
    localparam int PW_RAW = $clog2(PULSE_MIN_CYC + ANGLE_MAX * CYC_PER_DEG + 1);
    localparam int PW     = (PW_RAW > 8) ? PW_RAW : 8;
    localparam int CW     = (PW > CNT_W) ? PW : CNT_W;
    localparam int OC_W   = $clog2(OC_FRAMES + 1);
    localparam logic [PW-1:0] PULSE_RST = PW'(PULSE_MIN_CYC + RESET_ANGLE * CYC_PER_DEG);

    angle_t          cur;
    angle_t          target;
    angle_t          cur_next;
    logic [PW-1:0]   pulse;
    logic [PW-1:0]   pulse_next;
    logic [OC_W-1:0] oc_cnt;
    logic [OC_W-1:0] oc_next;
    logic            over;
    logic            clr_lat;

    always_comb begin
        cur_next = cur;
        if (state == RUN) begin
            if (target > cur) begin
                cur_next = (target - cur <= angle_t'(SLEW_DEG)) ? target : cur + angle_t'(SLEW_DEG);
            end else if (target < cur) begin
                cur_next = (cur - target <= angle_t'(SLEW_DEG)) ? target : cur - angle_t'(SLEW_DEG);
            end
        end
        // Full-width product so the largest angle cannot wrap the pulse length.
        pulse_next = PW'(PULSE_MIN_CYC) + PW'(cur_next) * PW'(CYC_PER_DEG);
        over       = current > CUR_W'(OC_LIMIT);
        oc_next    = over ? oc_cnt + 1'b1 : '0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            cur     <= angle_t'(RESET_ANGLE);
            target  <= angle_t'(RESET_ANGLE);
            pulse   <= PULSE_RST;
            oc_cnt  <= '0;
            clr_lat <= 1'b0;
            pwm     <= 1'b0;
        end else begin
            if (wr) target <= wr_angle;
            // High for cnt values 1..pulse, i.e. starting the cycle after frame_start.
            pwm <= (state == RUN) && !update && (CW'(cnt) < CW'(pulse));
            if (update) begin
                clr_lat <= 1'b0;
                cur     <= cur_next;
                pulse   <= pulse_next;
                case (state)
                    IDLE: begin
                        oc_cnt <= '0;
                        if (en) state <= RUN;
                    end
                    RUN: begin
                        oc_cnt <= oc_next;
                        if (oc_next == OC_W'(OC_FRAMES)) begin
                            state <= FAULT;
                        end else if (!en) begin
                            state  <= IDLE;
                            oc_cnt <= '0;
                        end
                    end
                    FAULT: begin
                        // A clear latched during the frame that tripped was seen in RUN and is dropped.
                        if (clr_lat || fault_clr) begin
                            state  <= IDLE;
                            oc_cnt <= '0;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end else if (fault_clr) begin
                clr_lat <= 1'b1;
            end
        end
    end

    assign busy = (cur != target);

endmodule

// File: rtl/servo_pwm_multi.sv
// Multi-channel servo PWM: shared frame counter, command decode with angle clamp,
// and N_CH servo_ch instances updated together at the end of each frame.
module servo_pwm_multi import servo_pkg::*; #(
    parameter int N_CH          = 4,
    parameter int PERIOD_CYC    = 2000000,
    parameter int PULSE_MIN_CYC = 100000,
    parameter int CYC_PER_DEG   = 555,
    parameter int SLEW_DEG      = 5,
    parameter int CUR_W         = 12,
    parameter int OC_LIMIT      = 3000,
    parameter int OC_FRAMES     = 3,
    parameter int RESET_ANGLE   = 90
) (
    input  logic                       clk,
    input  logic                       rst_n,
    servo_pwm_multi_if.slave           cmd,
    input  logic [N_CH-1:0]            en,
    input  logic [N_CH-1:0]            fault_clr,
    input  logic [N_CH-1:0][CUR_W-1:0] measure_current,
    output logic [N_CH-1:0]            pwm_out,
    output logic [N_CH-1:0]            fault,
    output logic [N_CH-1:0]            busy,
    output logic                       frame_start
);
    localparam int CNT_W = (PERIOD_CYC > 1) ? $clog2(PERIOD_CYC) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(PERIOD_CYC - 1);

    logic [CNT_W-1:0] cnt;
    logic             update;
    logic             accept;
    angle_t           angle_clamped;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else begin
            cnt <= update ? '0 : cnt + 1'b1;
        end
    end

    assign update      = (cnt == CNT_LAST);
    assign frame_start = (cnt == '0);
    // Refusing commands on the update edge keeps target writes off the frame boundary.
    assign cmd.cmd_ready = rst_n && !update;
    assign accept        = cmd.cmd_valid && cmd.cmd_ready;
    assign angle_clamped = clamp_angle(cmd.cmd_angle);

    for (genvar i = 0; i < N_CH; i++) begin : g_ch
        logic      wr;
        ch_state_t state;

        // Channel numbers with no instance match nothing and are silently dropped.
        assign wr = accept && (32'(cmd.cmd_ch) == i);

        servo_ch #(
            .CNT_W        (CNT_W),
            .PULSE_MIN_CYC(PULSE_MIN_CYC),
            .CYC_PER_DEG  (CYC_PER_DEG),
            .SLEW_DEG     (SLEW_DEG),
            .CUR_W        (CUR_W),
            .OC_LIMIT     (OC_LIMIT),
            .OC_FRAMES    (OC_FRAMES),
            .RESET_ANGLE  (RESET_ANGLE)
        ) u_ch (
            .clk      (clk),
            .rst_n    (rst_n),
            .cnt      (cnt),
            .update   (update),
            .en       (en[i]),
            .fault_clr(fault_clr[i]),
            .current  (measure_current[i]),
            .wr       (wr),
            .wr_angle (angle_clamped),
            .pwm      (pwm_out[i]),
            .busy     (busy[i]),
            .state    (state)
        );

        assign fault[i] = (state == FAULT);
    end

endmodule

// File: doc/servo_pwm_multi.md
SERVO_PWM_MULTI -- requirements
Module: servo_pwm_multi

Interface
REQ-001 Parameters SHALL be name, default, meaning:
- N_CH, 4: number of servo channels
- PERIOD_CYC, 2000000: frame length in clk cycles (20 ms at 100 MHz)
- PULSE_MIN_CYC, 100000: pulse width at 0 deg
- CYC_PER_DEG, 555: added cycles per degree
- SLEW_DEG, 5: maximum angle change per frame
- CUR_W, 12: current-sample width
- OC_LIMIT, 3000: overcurrent threshold (strictly greater trips)
- OC_FRAMES, 3: consecutive overcurrent frames to fault
- RESET_ANGLE, 90: angle after reset
REQ-002 Ports SHALL be name, direction, width, meaning:
- clk, in, 1: single clock
- rst_n, in, 1: asynchronous active-low reset
- cmd_valid, in, 1: command strobe
- cmd_ready, out, 1: command accept
- cmd_ch, in, clog2(N_CH): target channel
- cmd_angle, in, 8: target angle in degrees
- en, in, N_CH: per-channel enable
- fault_clr, in, N_CH: per-channel fault clear pulse
- measure_current, in, N_CH x CUR_W: unsigned current samples
- pwm_out, out, N_CH: servo PWM outputs
- fault, out, N_CH: channel in FAULT
- busy, out, N_CH: current angle differs from target
- frame_start, out, 1: one-cycle frame marker

Function
REQ-003 A shared counter cnt SHALL count 0..PERIOD_CYC-1 and wrap to 0; frame_start SHALL be 1 exactly when cnt==0.
REQ-004 The frame update SHALL occur on the clock edge where cnt==PERIOD_CYC-1; all per-channel state, angle and pulse registers change only at this edge.
REQ-005 cmd_ready SHALL be 0 when cnt==PERIOD_CYC-1 and 1 otherwise; a command transfers when cmd_valid&&cmd_ready.
REQ-006 An accepted command SHALL write target[cmd_ch]=min(cmd_angle,180) on the next edge; cmd_ch>=N_CH SHALL be accepted and discarded.
REQ-007 At a frame update in RUN, cur SHALL become target if |target-cur|<=SLEW_DEG, else move SLEW_DEG toward target; in IDLE or FAULT, cur SHALL be held.
REQ-008 At each frame update, pulse SHALL be loaded with PULSE_MIN_CYC+cur_next*CYC_PER_DEG, computed without overflow at full width.
REQ-009 pwm_out[i] SHALL be registered and high for exactly pulse[i] cycles, starting the cycle after frame_start, only while channel i is in RUN.
REQ-010 Each channel SHALL implement states IDLE, RUN and FAULT, with transitions only at frame update:
- IDLE->RUN when en[i]=1
- RUN->IDLE when en[i]=0
- RUN->FAULT when the overcurrent count reaches OC_FRAMES
- FAULT->IDLE on a latched fault_clr[i]
REQ-011 The overcurrent count SHALL update at each frame update in RUN: increment when measure_current[i]>OC_LIMIT, otherwise clear to 0; it SHALL be cleared on entering IDLE.
REQ-012 fault_clr[i] SHALL be latched when it arrives and consumed at the next frame update; a clear arriving in the same update as a trip SHALL be ignored, so FAULT wins.
REQ-013 In FAULT, en SHALL be ignored and pwm_out SHALL be 0; a pulse in progress when en drops SHALL complete, since the state changes only at the frame boundary.
REQ-014 fault[i] SHALL equal (state==FAULT); busy[i] SHALL equal (cur!=target).

Reset
REQ-015 While rst_n=0, regardless of clk, the block SHALL hold:
- cnt=0
- all channels IDLE
- cur=target=RESET_ANGLE
- pulse=PULSE_MIN_CYC+RESET_ANGLE*CYC_PER_DEG
- overcurrent counts and clear latches at 0
- pwm_out=0, fault=0, busy=0, cmd_ready=0
REQ-016 Reset asserted mid-pulse SHALL drive pwm_out low immediately; after release, the first frame_start SHALL occur on the first clock with cnt==0.

Structure
REQ-017 Package servo_pkg SHALL hold the ch_state_t enum (IDLE, RUN, FAULT), ANGLE_MAX=180 and the angle type.
REQ-018 Per-channel logic (state, slew, overcurrent, pulse, pwm) SHALL be a sub-module servo_ch, instantiated N_CH times by generate; the counter and command decode SHALL stay in servo_pwm_multi.

Verification
Bench parameters: N_CH=4, PERIOD_CYC=1000, PULSE_MIN_CYC=50, CYC_PER_DEG=1, SLEW_DEG=10, OC_FRAMES=3.
REQ-019 Directed scenarios:
- Reset, then en=1 on ch0 with no command -> from the second frame, ch0 shows 140-cycle pulses every 1000 cycles; other channels stay low.
- Send ch1 angle 120 from 90, en[1]=1 -> pulse widths 140 (IDLE->RUN frame), 150, 160, 170, then 170 steady; busy[1] clears once pulse reaches 170.
- Send angle 250 -> clamped to 180, final pulse 230; cmd_valid at cnt==999 -> cmd_ready=0 and no write until the next cycle.
- ch2 current 3001 for 3 frames -> fault[2]=1 and pwm low; fault_clr with en=1 -> IDLE, then RUN one frame later.
- Current 3001 twice then 3000 once, then 3001 twice -> no fault; fault_clr in the same update as a trip -> fault remains set.
- rst_n low at cnt=100 mid-pulse -> pwm_out=0 and cur=target=90 immediately.
